// File: rtl/eth_arp_responder_pkg.sv
// Shared ARP/Ethernet constants, word offsets and FSM state type for the ARP responder.
package eth_arp_responder_pkg;

   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ARP_HTYPE      = 16'h0001;
   localparam logic [15:0] ARP_PTYPE      = 16'h0800;
   localparam logic [15:0] ARP_HLPL       = 16'h0604;
   localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
   localparam logic [15:0] ARP_OPER_REP   = 16'h0002;

   localparam logic [10:0] ARP_OFF_ETYPE = 11'd6;
   localparam logic [10:0] ARP_OFF_HTYPE = 11'd7;
   localparam logic [10:0] ARP_OFF_PTYPE = 11'd8;
   localparam logic [10:0] ARP_OFF_HLPL  = 11'd9;
   localparam logic [10:0] ARP_OFF_OPER  = 11'd10;
   localparam logic [10:0] ARP_OFF_SHA   = 11'd11;
   localparam logic [10:0] ARP_OFF_SPA   = 11'd14;
   localparam logic [10:0] ARP_OFF_TPA   = 11'd19;

   localparam int unsigned TX_LEN_WORDS_DEF = 30;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REPLY,
      ST_FINISH
   } arp_state_t;

   // Rx word fetched at each step of the header check, in issue order.
   function automatic logic [10:0] check_addr(input logic [4:0] step);
      case (step)
         5'd0:    return ARP_OFF_ETYPE;
         5'd1:    return ARP_OFF_HTYPE;
         5'd2:    return ARP_OFF_PTYPE;
         5'd3:    return ARP_OFF_HLPL;
         5'd4:    return ARP_OFF_OPER;
         5'd5:    return ARP_OFF_TPA;
         5'd6:    return ARP_OFF_TPA + 11'd1;
         default: return 11'd0;
      endcase
   endfunction

endpackage

// File: rtl/eth_arp_responder.sv
// ARP responder: validates an ARP request in the Rx buffer and writes the reply body into the Tx buffer.
// state     | meaning
// ST_IDLE   | waiting for Parcer_RQ
// ST_CHECK  | streaming EtherType/ARP header words and comparing them as they return
// ST_REPLY  | writing Tx words 6..29, counter holds the Tx word index
// ST_FINISH | Tx_Start pulse with Tx_Length
module eth_arp_responder
   import eth_arp_responder_pkg::*;
#(
   parameter int Eth_WORD_WIDTH = 16,
   parameter int TX_LEN_WORDS   = TX_LEN_WORDS_DEF
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic                      Parcer_RQ,
   output logic [10:0]               Rx_Addr,
   input  logic [Eth_WORD_WIDTH-1:0] Rx_Data,
   output logic [10:0]               Tx_Addr,
   output logic [Eth_WORD_WIDTH-1:0] Tx_Data,
   output logic                      Tx_Word_Strobe,
   output logic                      Tx_Start,
   output logic [10:0]               Tx_Length,
   input  logic [Eth_WORD_WIDTH-1:0] MAC_Addr0_i,
   input  logic [Eth_WORD_WIDTH-1:0] MAC_Addr1_i,
   input  logic [Eth_WORD_WIDTH-1:0] MAC_Addr2_i,
   input  logic [Eth_WORD_WIDTH-1:0] IP_Addr0_i,
   input  logic [Eth_WORD_WIDTH-1:0] IP_Addr1_i,
   output logic                      Next_Parcer,
   output logic                      Rx_Error_Type,
   output logic                      Rx_Drop,
   output logic                      Busy
);

   arp_state_t                state, state_next;
   logic [4:0]                cnt, cnt_next;
   logic [10:0]               rx_addr_next;
   logic                      np_next, err_next, drop_next;
   logic [Eth_WORD_WIDTH-1:0] field_exp;
   logic [Eth_WORD_WIDTH-1:0] tx_word;

   // In CHECK, cnt==k means data for check step k-1 is on Rx_Data.
   always_comb begin
      field_exp = '0;
      case (cnt)
         5'd2:    field_exp = ARP_HTYPE;
         5'd3:    field_exp = ARP_PTYPE;
         5'd4:    field_exp = ARP_HLPL;
         5'd5:    field_exp = ARP_OPER_REQ;
         5'd6:    field_exp = IP_Addr0_i;
         5'd7:    field_exp = IP_Addr1_i;
         default: field_exp = '0;
      endcase
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      rx_addr_next = 11'd0;
      np_next      = 1'b0;
      err_next     = 1'b0;
      drop_next    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Parcer_RQ) begin
               state_next   = ST_CHECK;
               cnt_next     = 5'd0;
               rx_addr_next = check_addr(5'd0);
            end
         end
         ST_CHECK: begin
            cnt_next     = cnt + 5'd1;
            rx_addr_next = check_addr(cnt + 5'd1);
            if (cnt == 5'd1) begin
               if (Rx_Data != ARP_ETYPE_W()) begin
                  state_next   = ST_IDLE;
                  rx_addr_next = 11'd0;
                  np_next      = (Rx_Data == ETHERTYPE_IPV4);
                  err_next     = (Rx_Data != ETHERTYPE_IPV4);
               end
            end else if (cnt >= 5'd2) begin
               if (Rx_Data != field_exp) begin
                  state_next   = ST_IDLE;
                  rx_addr_next = 11'd0;
                  drop_next    = 1'b1;
               end else if (cnt == 5'd7) begin
                  state_next = ST_REPLY;
                  cnt_next   = 5'd6;
               end
            end
         end
         ST_REPLY: begin
            cnt_next = cnt + 5'd1;
            // Prefetch SHA/SPA one cycle ahead so each lands as its Tx word is written.
            if (cnt >= 5'd14 && cnt <= 5'd18) rx_addr_next = {6'd0, cnt} - 11'd3;
            if (cnt == 5'd29) state_next = ST_FINISH;
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
            cnt_next   = 5'd0;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   function automatic logic [Eth_WORD_WIDTH-1:0] ARP_ETYPE_W();
      return ETHERTYPE_ARP;
   endfunction

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= ST_IDLE;
         cnt           <= 5'd0;
         Rx_Addr       <= 11'd0;
         Next_Parcer   <= 1'b0;
         Rx_Error_Type <= 1'b0;
         Rx_Drop       <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         Rx_Addr       <= rx_addr_next;
         Next_Parcer   <= np_next;
         Rx_Error_Type <= err_next;
         Rx_Drop       <= drop_next;
      end
   end

   always_comb begin
      tx_word = '0;
      case (cnt)
         5'd6:                        tx_word = ETHERTYPE_ARP;
         5'd7:                        tx_word = ARP_HTYPE;
         5'd8:                        tx_word = ARP_PTYPE;
         5'd9:                        tx_word = ARP_HLPL;
         5'd10:                       tx_word = ARP_OPER_REP;
         5'd11:                       tx_word = MAC_Addr0_i;
         5'd12:                       tx_word = MAC_Addr1_i;
         5'd13:                       tx_word = MAC_Addr2_i;
         5'd14:                       tx_word = IP_Addr0_i;
         5'd15:                       tx_word = IP_Addr1_i;
         5'd16, 5'd17, 5'd18, 5'd19,
         5'd20:                       tx_word = Rx_Data;
         default:                     tx_word = '0;
      endcase
   end

   assign Tx_Word_Strobe = (state == ST_REPLY);
   assign Tx_Addr        = Tx_Word_Strobe ? {6'd0, cnt} : 11'd0;
   assign Tx_Data        = Tx_Word_Strobe ? tx_word : '0;
   assign Tx_Start       = (state == ST_FINISH);
   assign Tx_Length      = Tx_Start ? 11'(TX_LEN_WORDS) : 11'd0;
   assign Busy           = (state != ST_IDLE);

endmodule
